// File: rtl/branch_cmp_arbiter_if.sv
// rtl/branch_cmp_arbiter_if.sv - request/comparator/response bundle for branch_cmp_arbiter
interface branch_cmp_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      i_req_valid;
  logic [NUM_REQ-1:0]      o_req_ready;
  logic [NUM_REQ-1:0]      i_req_is_branch;
  logic [NUM_REQ-1:0]      i_req_slt_op;
  logic [NUM_REQ-1:0]      i_req_br_signed;
  logic [3*NUM_REQ-1:0]    i_req_funct3;
  logic [XLEN*NUM_REQ-1:0] i_req_rd1;
  logic [XLEN*NUM_REQ-1:0] i_req_rd2;
  logic                    o_cmp_is_branch;
  logic                    o_cmp_slt_op;
  logic                    o_cmp_br_signed;
  logic [2:0]              o_cmp_funct3;
  logic [XLEN-1:0]         o_cmp_rd1;
  logic [XLEN-1:0]         o_cmp_rd2;
  logic                    i_cmp_slt;
  logic                    i_cmp_branch_valid;
  logic [NUM_REQ-1:0]      o_rsp_valid;
  logic [NUM_REQ-1:0]      i_rsp_ready;
  logic [NUM_REQ-1:0]      o_rsp_taken;
  logic [NUM_REQ-1:0]      o_rsp_slt;

  modport slave (
    input  i_req_valid, i_req_is_branch, i_req_slt_op, i_req_br_signed,
    input  i_req_funct3, i_req_rd1, i_req_rd2,
    input  i_cmp_slt, i_cmp_branch_valid, i_rsp_ready,
    output o_req_ready, o_cmp_is_branch, o_cmp_slt_op, o_cmp_br_signed,
    output o_cmp_funct3, o_cmp_rd1, o_cmp_rd2,
    output o_rsp_valid, o_rsp_taken, o_rsp_slt
  );

  modport master (
    output i_req_valid, i_req_is_branch, i_req_slt_op, i_req_br_signed,
    output i_req_funct3, i_req_rd1, i_req_rd2,
    output i_cmp_slt, i_cmp_branch_valid, i_rsp_ready,
    input  o_req_ready, o_cmp_is_branch, o_cmp_slt_op, o_cmp_br_signed,
    input  o_cmp_funct3, o_cmp_rd1, o_cmp_rd2,
    input  o_rsp_valid, o_rsp_taken, o_rsp_slt
  );
endinterface

// File: rtl/branch_cmp_arbiter.sv
// rtl/branch_cmp_arbiter.sv - round-robin sharing of one branch/SLT comparator
module branch_cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  branch_cmp_arbiter_if.slave   bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} rsp_state_e;

  rsp_state_e         state_q [NUM_REQ];
  rsp_state_e         state_d [NUM_REQ];
  logic [PW-1:0]      rr_ptr_q;
  logic [PW-1:0]      rr_ptr_d;
  logic [NUM_REQ-1:0] taken_q;
  logic [NUM_REQ-1:0] slt_q;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;

  // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input logic [PW-1:0] ptr);
    logic [NUM_REQ-1:0] onehot;
    logic               found;
    int                 idx;
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && elig[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid[k] = (state_q[k] == HELD);
    end
  end

  // A held response frees its slot in the same cycle it is consumed.
  assign eligible = bus.i_req_valid & (~rsp_valid | bus.i_rsp_ready);
  assign grant    = i_rst_n ? rr_pick(eligible, rr_ptr_q) : '0;

  assign bus.o_req_ready = grant;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_taken = taken_q;
  assign bus.o_rsp_slt   = slt_q;

  always_comb begin
    bus.o_cmp_is_branch = 1'b0;
    bus.o_cmp_slt_op    = 1'b0;
    bus.o_cmp_br_signed = 1'b0;
    bus.o_cmp_funct3    = 3'b000;
    bus.o_cmp_rd1       = '0;
    bus.o_cmp_rd2       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        bus.o_cmp_is_branch = bus.i_req_is_branch[k];
        bus.o_cmp_slt_op    = bus.i_req_slt_op[k];
        bus.o_cmp_br_signed = bus.i_req_br_signed[k];
        bus.o_cmp_funct3    = bus.i_req_funct3[3*k +: 3];
        bus.o_cmp_rd1       = bus.i_req_rd1[XLEN*k +: XLEN];
        bus.o_cmp_rd2       = bus.i_req_rd2[XLEN*k +: XLEN];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        rr_ptr_d = PW'((k + 1) % NUM_REQ);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        IDLE: if (grant[k]) state_d[k] = HELD;
        HELD: if (bus.i_rsp_ready[k] && !grant[k]) state_d[k] = IDLE;
        default: state_d[k] = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        state_q[k] <= IDLE;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < NUM_REQ; k++) begin
        state_q[k] <= state_d[k];
      end
    end
  end

  // Result bits follow the comparator only for the requester granted this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      taken_q <= '0;
      slt_q   <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[k]) begin
          taken_q[k] <= bus.i_cmp_branch_valid;
          slt_q[k]   <= bus.i_cmp_slt;
        end
      end
    end
  end
endmodule
